// File: rtl/temporizador_mmss.sv
// -----------------------------------------------------------------------------
// temporizador_mmss
// BCD countdown timer, MM:SS, 00:00..59:59. Counts down one second per iTick
// pulse from the upstream clock divider. Raises oAlarm while expired and
// returns to IDLE on its own after ALARM_TICKS further ticks.
//
// Ports
//   iClk                      system clock, rising edge
//   iRst                      synchronous active-high reset
//   iTick                     1-cycle count enable (one per second)
//   iLoad                     load iMinT/iMinU/iSecT/iSecU (IDLE/DONE only)
//   iMinT/iMinU/iSecT/iSecU   BCD value to load (saturated to 59:59)
//   iStart / iStop            start/resume, pause
//   iClear                    abort and zero the count
//   oMinT/oMinU/oSecT/oSecU   current count, BCD
//   oState                    IDLE=0, RUN=1, PAUSE=2, DONE=3
//   oDone                     1-cycle pulse on entry to DONE
//   oAlarm                    high while in DONE
//
// state | meaning
// IDLE  | holding a value, waiting for iStart
// RUN   | decrementing on each iTick
// PAUSE | count frozen, waiting for iStart
// DONE  | reached 00:00, alarm on, counting ALARM_TICKS ticks
// -----------------------------------------------------------------------------
module temporizador_mmss #(
    parameter int ALARM_TICKS = 5
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick,
    input  logic       iLoad,
    input  logic [3:0] iMinT,
    input  logic [3:0] iMinU,
    input  logic [3:0] iSecT,
    input  logic [3:0] iSecU,
    input  logic       iStart,
    input  logic       iStop,
    input  logic       iClear,
    output logic [3:0] oMinT,
    output logic [3:0] oMinU,
    output logic [3:0] oSecT,
    output logic [3:0] oSecU,
    output logic [1:0] oState,
    output logic       oDone,
    output logic       oAlarm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS);

    state_t     state_q, state_d;
    logic [3:0] min_t_q, min_t_d;
    logic [3:0] min_u_q, min_u_d;
    logic [3:0] sec_t_q, sec_t_d;
    logic [3:0] sec_u_q, sec_u_d;
    logic [3:0] alm_cnt_q, alm_cnt_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;

    logic       cnt_zero;
    logic       cnt_one;
    logic [3:0] alm_cnt_inc;

    function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    assign cnt_zero    = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                         (sec_t_q == 4'd0) && (sec_u_q == 4'd0);
    assign cnt_one     = (min_t_q == 4'd0) && (min_u_q == 4'd0) &&
                         (sec_t_q == 4'd0) && (sec_u_q == 4'd1);
    assign alm_cnt_inc = alm_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        min_t_d   = min_t_q;
        min_u_d   = min_u_q;
        sec_t_d   = sec_t_q;
        sec_u_d   = sec_u_q;
        alm_cnt_d = alm_cnt_q;
        done_d    = 1'b0;

        if (iClear) begin
            state_d   = IDLE;
            min_t_d   = 4'd0;
            min_u_d   = 4'd0;
            sec_t_d   = 4'd0;
            sec_u_d   = 4'd0;
            alm_cnt_d = 4'd0;
        end else if (iLoad && (state_q == IDLE || state_q == DONE)) begin
            state_d   = IDLE;
            min_t_d   = sat(iMinT, 4'd5);
            min_u_d   = sat(iMinU, 4'd9);
            sec_t_d   = sat(iSecT, 4'd5);
            sec_u_d   = sat(iSecU, 4'd9);
            alm_cnt_d = 4'd0;
        end else begin
            // A load arriving in RUN/PAUSE is dropped; lower-priority inputs
            // are still evaluated below.
            case (state_q)
                IDLE: begin
                    if (iStart && !cnt_zero) state_d = RUN;
                end
                RUN: begin
                    if (iStop) begin
                        state_d = PAUSE;
                    end else if (iTick && !cnt_zero) begin
                        // Borrow chain, least significant digit first.
                        if (sec_u_q != 4'd0) begin
                            sec_u_d = sec_u_q - 4'd1;
                        end else begin
                            sec_u_d = 4'd9;
                            if (sec_t_q != 4'd0) begin
                                sec_t_d = sec_t_q - 4'd1;
                            end else begin
                                sec_t_d = 4'd5;
                                if (min_u_q != 4'd0) begin
                                    min_u_d = min_u_q - 4'd1;
                                end else begin
                                    min_u_d = 4'd9;
                                    min_t_d = min_t_q - 4'd1;
                                end
                            end
                        end
                        if (cnt_one) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            alm_cnt_d = 4'd0;
                        end
                    end
                end
                PAUSE: begin
                    if (!iStop && iStart) state_d = RUN;
                end
                DONE: begin
                    if (iTick) begin
                        if (alm_cnt_inc >= ALARM_LAST) begin
                            state_d   = IDLE;
                            alm_cnt_d = 4'd0;
                        end else begin
                            alm_cnt_d = alm_cnt_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        alarm_d = (state_d == DONE);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= IDLE;
            min_t_q   <= 4'd0;
            min_u_q   <= 4'd0;
            sec_t_q   <= 4'd0;
            sec_u_q   <= 4'd0;
            alm_cnt_q <= 4'd0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_t_q   <= min_t_d;
            min_u_q   <= min_u_d;
            sec_t_q   <= sec_t_d;
            sec_u_q   <= sec_u_d;
            alm_cnt_q <= alm_cnt_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign oMinT  = min_t_q;
    assign oMinU  = min_u_q;
    assign oSecT  = sec_t_q;
    assign oSecU  = sec_u_q;
    assign oState = state_q;
    assign oDone  = done_q;
    assign oAlarm = alarm_q;

endmodule

// File: tb/tb_temporizador_mmss.sv
module tb_temporizador_mmss;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iTick = 1'b0, iLoad = 1'b0, iStart = 1'b0, iStop = 1'b0, iClear = 1'b0;
    logic [3:0] iMinT = 4'd0, iMinU = 4'd0, iSecT = 4'd0, iSecU = 4'd0;
    logic [3:0] oMinT, oMinU, oSecT, oSecU;
    logic [1:0] oState;
    logic       oDone, oAlarm;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] exp_q[$];
    string       tag_q[$];

    // control bits: {rst, clear, load, stop, start, tick}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] RST  = 6'b100000;
    localparam logic [5:0] CLR  = 6'b010000;
    localparam logic [5:0] LD   = 6'b001000;
    localparam logic [5:0] SP   = 6'b000100;
    localparam logic [5:0] ST   = 6'b000010;
    localparam logic [5:0] TK   = 6'b000001;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    temporizador_mmss #(.ALARM_TICKS(5)) dut (
        .iClk(iClk), .iRst(iRst), .iTick(iTick), .iLoad(iLoad),
        .iMinT(iMinT), .iMinU(iMinU), .iSecT(iSecT), .iSecU(iSecU),
        .iStart(iStart), .iStop(iStop), .iClear(iClear),
        .oMinT(oMinT), .oMinU(oMinU), .oSecT(oSecT), .oSecU(oSecU),
        .oState(oState), .oDone(oDone), .oAlarm(oAlarm)
    );

    always #5 iClk = ~iClk;

    function automatic logic [19:0] pk(input logic [1:0] s, input logic [15:0] d,
                                       input logic dn, input logic al);
        return {s, d, dn, al};
    endfunction

    // Drive one cycle of inputs, push the expected post-edge result, then
    // pop and compare it 1 time unit after the edge.
    task automatic step(input string tag, input logic [5:0] ctl, input logic [15:0] v,
                        input logic [19:0] expv);
        logic [19:0] e;
        logic [19:0] obs;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        {iRst, iClear, iLoad, iStop, iStart, iTick} = ctl;
        {iMinT, iMinU, iSecT, iSecU} = v;
        @(posedge iClk);
        #1;
        {iRst, iClear, iLoad, iStop, iStart, iTick} = NONE;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {oState, oMinT, oMinU, oSecT, oSecU, oDone, oAlarm};
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed st=%0d %h:%h done=%b alarm=%b, expected st=%0d %h:%h done=%b alarm=%b",
                   t, obs[19:18], obs[17:10], obs[9:2], obs[1], obs[0],
                   e[19:18], e[17:10], e[9:2], e[1], e[0]);
        end
    endtask

    initial begin
        // reset state
        step("reset_init", RST, 16'h0000, pk(S_IDLE, 16'h0000, 0, 0));

        // borrow chain
        step("load_1000",   LD,   16'h1000, pk(S_IDLE, 16'h1000, 0, 0));
        step("idle_tick",   TK,   16'h0000, pk(S_IDLE, 16'h1000, 0, 0));
        step("start_1000",  ST,   16'h0000, pk(S_RUN,  16'h1000, 0, 0));
        step("borrow_0959", TK,   16'h0000, pk(S_RUN,  16'h0959, 0, 0));
        step("hold_0959",   NONE, 16'h0000, pk(S_RUN,  16'h0959, 0, 0));
        step("clear_a",     CLR,  16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("load_0100",   LD,   16'h0100, pk(S_IDLE, 16'h0100, 0, 0));
        step("start_0100",  ST,   16'h0000, pk(S_RUN,  16'h0100, 0, 0));
        step("borrow_0059", TK,   16'h0000, pk(S_RUN,  16'h0059, 0, 0));

        // reset mid-RUN at 12:34
        step("clear_b",     CLR,  16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("load_1234",   LD,   16'h1234, pk(S_IDLE, 16'h1234, 0, 0));
        step("start_1234",  ST,   16'h0000, pk(S_RUN,  16'h1234, 0, 0));
        step("tick_1233",   TK,   16'h0000, pk(S_RUN,  16'h1233, 0, 0));
        step("rst_run_1",   RST | TK, 16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("rst_run_2",   RST | ST, 16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("post_rst",    NONE, 16'h0000, pk(S_IDLE, 16'h0000, 0, 0));

        // expiry and alarm timeout
        step("load_0002",   LD,   16'h0002, pk(S_IDLE, 16'h0002, 0, 0));
        step("start_0002",  ST,   16'h0000, pk(S_RUN,  16'h0002, 0, 0));
        step("tick_0001",   TK,   16'h0000, pk(S_RUN,  16'h0001, 0, 0));
        step("expire",      TK,   16'h0000, pk(S_DONE, 16'h0000, 1, 1));
        step("done_pulse1", NONE, 16'h0000, pk(S_DONE, 16'h0000, 0, 1));
        step("done_start",  ST,   16'h0000, pk(S_DONE, 16'h0000, 0, 1));
        for (int i = 1; i <= 4; i++)
            step($sformatf("alarm_tick%0d", i), TK, 16'h0000, pk(S_DONE, 16'h0000, 0, 1));
        step("alarm_tick5", TK,   16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("idle_after",  TK,   16'h0000, pk(S_IDLE, 16'h0000, 0, 0));

        // pause behaviour
        step("load_0030",   LD,   16'h0030, pk(S_IDLE, 16'h0030, 0, 0));
        step("start_0030",  ST,   16'h0000, pk(S_RUN,  16'h0030, 0, 0));
        step("tick_0029",   TK,   16'h0000, pk(S_RUN,  16'h0029, 0, 0));
        step("tick_0028",   TK,   16'h0000, pk(S_RUN,  16'h0028, 0, 0));
        step("tick_0027",   TK,   16'h0000, pk(S_RUN,  16'h0027, 0, 0));
        step("stop_tick",   SP | TK, 16'h0000, pk(S_PAUSE, 16'h0027, 0, 0));
        for (int i = 1; i <= 4; i++)
            step($sformatf("pause_tick%0d", i), TK, 16'h0000, pk(S_PAUSE, 16'h0027, 0, 0));
        step("pause_st_sp", ST | SP, 16'h0000, pk(S_PAUSE, 16'h0027, 0, 0));
        step("resume_tick", ST | TK, 16'h0000, pk(S_RUN,   16'h0027, 0, 0));
        step("tick_0026",   TK,   16'h0000, pk(S_RUN,  16'h0026, 0, 0));

        // saturation and ignored inputs
        step("clear_c",     CLR,  16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("start_zero",  ST,   16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("sat_5959",    LD,   16'h9F7A, pk(S_IDLE, 16'h5959, 0, 0));
        step("sat_5953",    LD,   16'h7C63, pk(S_IDLE, 16'h5953, 0, 0));
        step("start_5953",  ST,   16'h0000, pk(S_RUN,  16'h5953, 0, 0));
        step("load_in_run", LD,   16'h0102, pk(S_RUN,  16'h5953, 0, 0));
        step("run_st_sp",   ST | SP | TK, 16'h0000, pk(S_PAUSE, 16'h5953, 0, 0));
        step("load_in_pse", LD,   16'h0102, pk(S_PAUSE, 16'h5953, 0, 0));

        // clear beats load in RUN
        step("clear_d",     CLR,  16'h0000, pk(S_IDLE, 16'h0000, 0, 0));
        step("load_0500",   LD,   16'h0500, pk(S_IDLE, 16'h0500, 0, 0));
        step("start_0500",  ST,   16'h0000, pk(S_RUN,  16'h0500, 0, 0));
        step("tick_0459",   TK,   16'h0000, pk(S_RUN,  16'h0459, 0, 0));
        step("clr_and_ld",  CLR | LD, 16'h0300, pk(S_IDLE, 16'h0000, 0, 0));

        // load exits DONE early
        step("load_0001",   LD,   16'h0001, pk(S_IDLE, 16'h0001, 0, 0));
        step("start_0001",  ST,   16'h0000, pk(S_RUN,  16'h0001, 0, 0));
        step("expire_b",    TK,   16'h0000, pk(S_DONE, 16'h0000, 1, 1));
        step("done_load",   LD,   16'h0010, pk(S_IDLE, 16'h0010, 0, 0));
        step("start_0010",  ST,   16'h0000, pk(S_RUN,  16'h0010, 0, 0));
        step("borrow_0009", TK,   16'h0000, pk(S_RUN,  16'h0009, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/temporizador_mmss.md
Name: temporizador_mmss

Overview:
- BCD countdown timer, MM:SS format, range 00:00 to 59:59.
- Sits directly downstream of the clock divider and consumes its 1-cycle tick pulse (one pulse per second at 50 MHz) as a count enable.
- Runs entirely in the iClk domain; no derived clocks.
- Drives the display decoder (four BCD digits) and an alarm indicator.

Parameters:
- ALARM_TICKS, 5: number of iTick pulses the alarm stays asserted in DONE before the FSM returns to IDLE automatically; legal range 1..15.

Ports:
- iClk      input   1  system clock; all logic on the rising edge.
- iRst      input   1  synchronous, active-high reset.
- iTick     input   1  1-cycle enable pulse from the clock divider; one pulse = one second.
- iLoad     input   1  load iMinT/iMinU/iSecT/iSecU into the count; level-sampled each cycle.
- iMinT     input   4  BCD minutes tens to load.
- iMinU     input   4  BCD minutes units to load.
- iSecT     input   4  BCD seconds tens to load.
- iSecU     input   4  BCD seconds units to load.
- iStart    input   1  start or resume counting.
- iStop     input   1  pause counting.
- iClear    input   1  abort the current operation and zero the count.
- oMinT     output  4  current minutes tens (0..5).
- oMinU     output  4  current minutes units (0..9).
- oSecT     output  4  current seconds tens (0..5).
- oSecU     output  4  current seconds units (0..9).
- oState    output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- oDone     output  1  1-cycle pulse on the transition into DONE.
- oAlarm    output  1  high for the whole time the FSM is in DONE.

Behaviour:
- All outputs are registered, in the same two-process style as the divider: next-state logic is combinational, and every register updates only on posedge iClk.
- Reset: iRst=1 at a rising edge sets state=IDLE, all digits=0, oDone=0, oAlarm=0 and the alarm counter to 0. Reset wins over every other input, including mid-RUN and mid-DONE.
- Input priority, evaluated each cycle: iRst > iClear > iLoad > iStop > iStart > iTick.
- iClear, any state: next state=IDLE, digits=00:00, alarm counter=0.
- iLoad:
  - Acted on only in IDLE or DONE; ignored in RUN and PAUSE.
  - Next state=IDLE.
  - Tens digits >5 saturate to 5; units digits >9 saturate to 9.
  - Example: load of MinT=7, MinU=12, SecT=6, SecU=3 gives 59:53.
- IDLE: iStart with count != 00:00 goes to RUN next cycle. iStart with count == 00:00 is ignored. iTick is ignored.
- RUN:
  - iStop goes to PAUSE. A tick in the same cycle is discarded and the count holds.
  - Otherwise, an iTick decrements the count by one second, visible on the outputs 1 cycle after the tick.
  - Borrow chain: SecU 0 becomes 9 and borrows from SecT; SecT 0 becomes 5 and borrows from MinU; MinU 0 becomes 9 and borrows from MinT.
  - The tick that takes 00:01 to 00:00 also moves the FSM to DONE in the same edge: oDone=1 for exactly that one cycle, oAlarm=1 from that edge on, alarm counter=0.
  - The count never wraps below 00:00.
- PAUSE: the count holds and iTick is ignored. iStart returns to RUN; a tick in the same cycle is not applied.
- DONE:
  - Digits stay at 00:00.
  - Each iTick increments the alarm counter.
  - When the counter reaches ALARM_TICKS, the next state is IDLE and oAlarm drops on that edge.
  - iStart is ignored. iLoad exits early to IDLE with the new value.
- iStart and iStop both high in RUN: stop wins, go to PAUSE. Both high in PAUSE: stop wins, stay in PAUSE.
- Input pulses are consumed level-wise each cycle; debounce and edge detection happen upstream.

Test Plan:
- Reset: assert iRst for 2 cycles during RUN at 12:34 -> after release, oState=0, digits 00:00, oDone=0, oAlarm=0.
- Borrow chain: load 10:00, start, 1 tick -> 09:59 one cycle after the tick. Load 01:00, 1 tick -> 00:59.
- Expiry: load 00:02, start, 2 ticks -> 00:00, oState=3, oDone high exactly 1 cycle, oAlarm high. With ALARM_TICKS=5, 5 further ticks -> oState=0, oAlarm=0.
- Pause: load 00:30, start, 3 ticks (00:27), iStop with a simultaneous tick -> stays 00:27 in PAUSE. 4 ticks -> still 00:27. iStart, then 1 tick -> 00:26.
- Saturation and ignores: load MinT=9, MinU=15, SecT=7, SecU=10 -> 59:59. iStart at 00:00 -> stays IDLE. iLoad during RUN -> count unaffected.
- Clear priority: in RUN at 05:00, iClear and iLoad=03:00 in the same cycle -> IDLE, 00:00.
